serial_tx: RTL and testbench
============================

Name: serial_tx

Overview:
- Byte-to-serial transmitter for the FPGA communication link; the sending end of the line that the link's bit-counting receiver samples.
- Accepts one byte per valid/ready handshake and shifts it out on a single line: start bit, 8 data bits LSB first, stop bit.
- Bit timing comes from an internal clock-enable divider, so the whole block runs on one clock domain.

Parameters:
- CLKS_PER_BIT, 8, clk cycles per serial bit; legal range 2..256.
- DATA_BITS, 8, data bits per frame; fixed at 8 for this link, kept as a parameter for the counter width.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- tx_data  in  8  byte to send; sampled only on the accepting edge.
- tx_valid  in  1  producer has a byte on tx_data.
- tx_ready  out  1  block can accept a byte this cycle.
- tx_line  out  1  serial output; idles high.
- busy  out  1  a frame is in progress (START, DATA or STOP).
- done  out  1  one-cycle pulse on the final cycle of a frame's stop bit.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: tx_line=1, tx_ready=1, busy=0, done=0, state=IDLE, shift register=0, bit counter=0, divider=0.
- States:
  - IDLE: tx_ready=1, tx_line=1.
  - START: tx_line=0.
  - DATA: tx_line=shift[0].
  - STOP: tx_line=1.
  - busy=1 in every state except IDLE.
- Accept: on a rising edge where tx_valid&tx_ready=1, the block loads tx_data into the shift register, clears the divider, and enters START.
  - tx_line is low from the first cycle after the accepting edge.
  - tx_ready drops in that same cycle.
  - tx_data is ignored at all other times.
- Divider: counts 0..CLKS_PER_BIT-1 in every non-IDLE state. bit_end=1 when divider==CLKS_PER_BIT-1. The divider wraps to 0 on bit_end.
- START→DATA on bit_end.
- DATA:
  - On each bit_end the shift register shifts right by 1 and the bit counter increments.
  - When the counter is at DATA_BITS-1 on bit_end, the counter wraps to 0 and the state goes to STOP.
  - Exactly 8 data bits are sent, each held for CLKS_PER_BIT cycles.
- STOP→IDLE on bit_end. done=1 during the cycle where STOP and bit_end are both true.
- Frame length: exactly 10*CLKS_PER_BIT cycles from the first low cycle to the last stop cycle.
  - Back-to-back frames have a minimum of 1 IDLE cycle of line-high between them.
  - Accept next occurs on the first IDLE edge.
- tx_valid held high in IDLE: a frame starts on every IDLE edge. No input buffering.
- tx_valid deasserted mid-frame: no effect, the frame completes.
- Changing tx_data mid-frame: no effect on the frame.
- Reset mid-frame: tx_line returns high immediately (asynchronous), without waiting for a clock edge. The partial frame is abandoned and no done pulse is produced.
- Release from reset: IDLE, ready on the first edge.
- tx_line is driven from a register, so it is glitch-free.

Decomposition:
- Shared package serial_pkg:
  - state encoding constants: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3.
  - FRAME_BITS=10.
  - LINE_IDLE=1'b1.
- Sub-module baud_tick: parameterised divider with clr and en inputs and a bit_end output; reusable by the receiver side.
- Bit counter, shift register and FSM stay in serial_tx.

Test Plan:
- Reset then idle, with rst pulsed asynchronously between edges → tx_line=1, tx_ready=1, busy=0, and outputs change without a clock edge.
- CLKS_PER_BIT=4, accept 0xA5 → tx_line samples every 4 cycles read 0,1,0,1,0,0,1,0,1,1.
  - done pulses in cycle 40 after accept.
  - tx_ready returns high in cycle 41.
- tx_valid held high with 0x00 then 0xFF → two complete frames with exactly 1 high IDLE cycle between them; data bits all 0 then all 1.
- Change tx_data and drop tx_valid mid-frame while sending 0x3C → transmitted bits remain 0,0,1,1,1,1,0,0.
- Assert rst during the DATA bit 3 of 0x81 → tx_line=1 at once, no done pulse; a new 0x81 sent after reset is a full correct frame.
- CLKS_PER_BIT=2 (minimum) → a frame is 20 cycles, and every bit lasts exactly 2 cycles.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial link transmitter and receiver.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int unsigned FRAME_BITS = 10;
  localparam logic        LINE_IDLE  = 1'b1;

endpackage

// File: rtl/baud_tick.sv
// Clock-enable bit-period divider: counts 0..CLKS_PER_BIT-1 while enabled.
module baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic bit_end_o,
  output logic pre_end_o
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CNT_W-1:0] cnt_q;

  assign bit_end_o = en_i && (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  // One cycle ahead of bit_end, lets callers register a pulse that lands on bit_end.
  assign pre_end_o = en_i && (cnt_q == CNT_W'(CLKS_PER_BIT - 2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= bit_end_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/serial_tx.sv
// Byte-to-serial transmitter: start bit, DATA_BITS data bits LSB first, stop bit.
module serial_tx
  import serial_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_line,
  output logic       busy,
  output logic       done
);

  localparam int unsigned BCNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  state_t                state_q;
  logic [DATA_BITS-1:0]  shift_q;
  logic [BCNT_W-1:0]     bitcnt_q;
  logic                  tx_line_q;
  logic                  tx_ready_q;
  logic                  busy_q;
  logic                  done_q;

  logic accept;
  logic bit_end;
  logic pre_end;

  assign accept = (state_q == IDLE) && tx_valid && tx_ready_q;

  baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (accept),
    .en_i     (state_q != IDLE),
    .bit_end_o(bit_end),
    .pre_end_o(pre_end)
  );

  // Outputs are set from the state being entered so they are all registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bitcnt_q   <= '0;
      tx_line_q  <= LINE_IDLE;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            shift_q    <= DATA_BITS'(tx_data);
            state_q    <= START;
            tx_line_q  <= 1'b0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state_q   <= DATA;
            tx_line_q <= shift_q[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            shift_q <= shift_q >> 1;
            if (bitcnt_q == BCNT_W'(DATA_BITS - 1)) begin
              bitcnt_q  <= '0;
              state_q   <= STOP;
              tx_line_q <= LINE_IDLE;
            end else begin
              bitcnt_q  <= bitcnt_q + BCNT_W'(1);
              tx_line_q <= shift_q[1];
            end
          end
        end
        STOP: begin
          if (pre_end) begin
            done_q <= 1'b1;
          end
          if (bit_end) begin
            state_q    <= IDLE;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_line  = tx_line_q;
  assign tx_ready = tx_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx at CLKS_PER_BIT=4 and the minimum of 2.
module tb_serial_tx;
  import serial_pkg::*;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data_a, tx_data_b;
  logic       tx_valid_a, tx_valid_b;
  logic       tx_ready_a, tx_ready_b;
  logic       tx_line_a, tx_line_b;
  logic       busy_a, busy_b;
  logic       done_a, done_b;

  int checks = 0;
  int errors = 0;

  serial_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8)) dut_a (
    .clk     (clk),
    .rst     (rst),
    .tx_data (tx_data_a),
    .tx_valid(tx_valid_a),
    .tx_ready(tx_ready_a),
    .tx_line (tx_line_a),
    .busy    (busy_a),
    .done    (done_a)
  );

  serial_tx #(.CLKS_PER_BIT(2), .DATA_BITS(8)) dut_b (
    .clk     (clk),
    .rst     (rst),
    .tx_data (tx_data_b),
    .tx_valid(tx_valid_b),
    .tx_ready(tx_ready_b),
    .tx_line (tx_line_b),
    .busy    (busy_b),
    .done    (done_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic line, input logic rdy,
                          input logic bsy, input logic dn);
    chk({tag, " line"},  32'(tx_line_a),  32'(line));
    chk({tag, " ready"}, 32'(tx_ready_a), 32'(rdy));
    chk({tag, " busy"},  32'(busy_a),     32'(bsy));
    chk({tag, " done"},  32'(done_a),     32'(dn));
  endtask

  // Called at a negedge while the DUT is idle; the next posedge accepts d.
  // exp_bits[i] is the line level for frame bit i (bit 0 = start).
  task automatic frame(input bit sel, input logic [7:0] d, input logic [9:0] exp_bits,
                       input bit hold_valid, input bit scramble);
    int cpb;
    int n;
    logic l, r, b, dn;
    cpb = sel ? 2 : 4;
    n   = int'(FRAME_BITS) * cpb;
    if (sel) begin tx_data_b = d; tx_valid_b = 1'b1; end
    else     begin tx_data_a = d; tx_valid_a = 1'b1; end
    @(negedge clk);
    if (!hold_valid) begin
      if (sel) tx_valid_b = 1'b0; else tx_valid_a = 1'b0;
    end
    for (int c = 1; c <= n; c++) begin
      l  = sel ? tx_line_b  : tx_line_a;
      r  = sel ? tx_ready_b : tx_ready_a;
      b  = sel ? busy_b     : busy_a;
      dn = sel ? done_b     : done_a;
      chk($sformatf("d%0h c%0d line", d, c), 32'(l), 32'(exp_bits[(c - 1) / cpb]));
      chk($sformatf("d%0h c%0d ready", d, c), 32'(r), 32'd0);
      chk($sformatf("d%0h c%0d busy", d, c), 32'(b), 32'd1);
      chk($sformatf("d%0h c%0d done", d, c), 32'(dn), 32'(c == n));
      if (scramble) begin
        tx_data_a  = 8'($urandom);
        tx_valid_a = (c % 3 == 1);
      end
      @(negedge clk);
    end
    if (scramble) tx_valid_a = 1'b0;
    l  = sel ? tx_line_b  : tx_line_a;
    r  = sel ? tx_ready_b : tx_ready_a;
    b  = sel ? busy_b     : busy_a;
    dn = sel ? done_b     : done_a;
    chk($sformatf("d%0h idle line", d), 32'(l), 32'd1);
    chk($sformatf("d%0h idle ready", d), 32'(r), 32'd1);
    chk($sformatf("d%0h idle busy", d), 32'(b), 32'd0);
    chk($sformatf("d%0h idle done", d), 32'(dn), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    tx_data_a  = 8'h00;
    tx_data_b  = 8'h00;
    tx_valid_a = 1'b0;
    tx_valid_b = 1'b0;

    // Reset applied before any clock edge
    #1;
    chk_outs("rst0", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("rst0 b line", 32'(tx_line_b), 32'd1);
    chk("rst0 b ready", 32'(tx_ready_b), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_outs("idle", 1'b1, 1'b1, 1'b0, 1'b0);

    // Idle reset pulse between edges
    #2 rst = 1'b1;
    #1 chk_outs("idle rstpulse", 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 0xA5: 0,1,0,1,0,0,1,0,1,1; done in cycle 40, ready back in 41
    frame(1'b0, 8'hA5, 10'b1101001010, 1'b0, 1'b0);

    // Valid held: 0x00 then 0xFF back to back with one idle cycle
    frame(1'b0, 8'h00, 10'b1000000000, 1'b1, 1'b0);
    frame(1'b0, 8'hFF, 10'b1111111110, 1'b0, 1'b0);
    @(negedge clk);

    // 0x3C with tx_data and tx_valid changing mid-frame
    frame(1'b0, 8'h3C, 10'b1001111000, 1'b0, 1'b1);
    @(negedge clk);

    // 0x81 interrupted by reset during data bit 3
    tx_data_a  = 8'h81;
    tx_valid_a = 1'b1;
    @(negedge clk);
    tx_valid_a = 1'b0;
    repeat (17) @(negedge clk);
    chk_outs("x81 pre-rst", 1'b0, 1'b0, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 chk_outs("x81 async rst", 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_outs($sformatf("x81 in rst %0d", i), 1'b1, 1'b1, 1'b0, 1'b0);
    end
    rst = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      chk($sformatf("x81 no done %0d", i), 32'(done_a), 32'd0);
    end
    frame(1'b0, 8'h81, 10'b1100000010, 1'b0, 1'b0);

    // Minimum bit period: 20-cycle frame, 2 cycles per bit
    frame(1'b1, 8'hA5, 10'b1101001010, 1'b0, 1'b0);
    @(negedge clk);
    frame(1'b1, 8'h6E, 10'b1011011100, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
